// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction push and result pop handshakes of the ALU sequencer
interface alu_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_instr;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_x;
  logic [7:0]  res_y;
  logic        res_ovf;
  logic        res_carry;
  logic [1:0]  res_op;
  modport master (
    output in_valid, in_instr, res_ready,
    input  in_ready, res_valid, res_x, res_y, res_ovf, res_carry, res_op
  );
  modport slave (
    input  in_valid, in_instr, res_ready,
    output in_ready, res_valid, res_x, res_y, res_ovf, res_carry, res_op
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: FIFO-buffered issue/settle/capture sequencer for the 8-bit ALU; defining ALU_SEQ_STAT_EN adds saturating flag counters
module alu_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic [17:0]   alu_instr,
  input  logic [7:0]    alu_x,
  input  logic [7:0]    alu_y,
  input  logic          alu_ovf,
  input  logic          alu_carry,
`ifdef ALU_SEQ_STAT_EN
  input  logic          stat_clr,
  output logic [7:0]    ovf_cnt,
  output logic [7:0]    carry_cnt,
`endif
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [17:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [LW-1:0] lat;
  logic full, empty, push, pop, cap, rel, add_op;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign busy = state != IDLE || !empty;
  assign add_op = alu_instr[17:16] == 2'b00;
  // per-state strobes and next state; pop/capture/release are mutually exclusive by state
  always_comb begin
    pop = state == IDLE && !empty;
    cap = state == EXEC && lat == LW'(1);
    rel = state == DONE && bus.res_ready;
    state_nx = pop ? EXEC : cap ? DONE : rel ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // instruction storage; contents are meaningless outside the occupied window so no reset
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.in_instr;
  // circular pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  // issue, settle countdown and result capture; flags only mean something for add
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_instr <= '0;
      lat <= '0;
      bus.res_valid <= 1'b0;
      bus.res_x <= '0;
      bus.res_y <= '0;
      bus.res_ovf <= 1'b0;
      bus.res_carry <= 1'b0;
      bus.res_op <= '0;
    end else begin
      if (pop) begin
        alu_instr <= mem[rp];
        lat <= LW'(ALU_LAT);
      end else if (state == EXEC) lat <= lat - LW'(1);
      if (cap) begin
        bus.res_valid <= 1'b1;
        bus.res_x <= alu_x;
        bus.res_y <= alu_y;
        bus.res_ovf <= alu_ovf && add_op;
        bus.res_carry <= alu_carry && add_op;
        bus.res_op <= alu_instr[17:16];
      end else if (rel) bus.res_valid <= 1'b0;
    end
`ifdef ALU_SEQ_STAT_EN
  // saturating counts of masked flags seen at capture; clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_cnt <= '0;
      carry_cnt <= '0;
    end else if (stat_clr) begin
      ovf_cnt <= '0;
      carry_cnt <= '0;
    end else begin
      if (cap && alu_ovf && add_op && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (cap && alu_carry && add_op && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: vector table, hand sequences and randomized traffic against a queue scoreboard
module tb_alu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, rst1_n;
  logic [17:0] alu_instr0, alu_instr1;
  logic [7:0] alu_x0, alu_y0, alu_x1, alu_y1;
  logic alu_ovf0, alu_carry0, alu_ovf1, alu_carry1, busy0, busy1;
  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];
  typedef struct {
    logic [17:0] instr;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        ovf;
    logic        carry;
  } vec_t;
  vec_t tv[10];
  logic [17:0] bp[6];

  always #5 clk = ~clk;

  alu_seq_ctrl_if b0();
  alu_seq_ctrl_if b1();

`ifdef ALU_SEQ_STAT_EN
  logic stat_clr0, stat_clr1;
  logic [7:0] ovf_cnt0, carry_cnt0, ovf_cnt1, carry_cnt1;
`endif

  alu_seq_ctrl #(.DEPTH(4), .ALU_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .alu_instr(alu_instr0),
    .alu_x(alu_x0), .alu_y(alu_y0), .alu_ovf(alu_ovf0), .alu_carry(alu_carry0),
`ifdef ALU_SEQ_STAT_EN
    .stat_clr(stat_clr0), .ovf_cnt(ovf_cnt0), .carry_cnt(carry_cnt0),
`endif
    .busy(busy0)
  );

  alu_seq_ctrl #(.DEPTH(4), .ALU_LAT(3)) u1 (
    .clk(clk), .rst_n(rst1_n), .bus(b1), .alu_instr(alu_instr1),
    .alu_x(alu_x1), .alu_y(alu_y1), .alu_ovf(alu_ovf1), .alu_carry(alu_carry1),
`ifdef ALU_SEQ_STAT_EN
    .stat_clr(stat_clr1), .ovf_cnt(ovf_cnt1), .carry_cnt(carry_cnt1),
`endif
    .busy(busy1)
  );

  // ALU stand-in: non-add ops raise raw flags so masking is exercised
  function automatic logic [17:0] alu_f(input logic [17:0] i);
    logic [8:0] s;
    logic signed [15:0] p;
    s = {1'b0, i[15:8]} + {1'b0, i[7:0]};
    p = $signed(i[15:8]) * $signed(i[7:0]);
    case (i[17:16])
      2'd0: alu_f = {i[15] == i[7] && s[7] != i[15], s[8], 8'h00, s[7:0]};
      2'd1: alu_f = {2'b11, p};
      2'd2: alu_f = {2'b11, 8'h00, i[15:8] & i[7:0]};
      default: alu_f = {2'b11, 8'h00, i[15:8] ^ i[7:0]};
    endcase
  endfunction

  assign {alu_ovf0, alu_carry0, alu_x0, alu_y0} = alu_f(alu_instr0);
  assign {alu_ovf1, alu_carry1, alu_x1, alu_y1} = alu_f(alu_instr1);

  // expected result {op, ovf, carry, x, y} from integer arithmetic
  function automatic logic [19:0] ref_res(input logic [17:0] i);
    int a, b, sa, sbv, r;
    logic [7:0] x, y;
    logic o, c;
    a = int'(i[15:8]);
    b = int'(i[7:0]);
    sa = a > 127 ? a - 256 : a;
    sbv = b > 127 ? b - 256 : b;
    x = 8'h00;
    y = 8'h00;
    o = 1'b0;
    c = 1'b0;
    case (i[17:16])
      2'd0: begin
        r = a + b;
        y = 8'(r);
        c = r > 255;
        o = (sa + sbv > 127) || (sa + sbv < -128);
      end
      2'd1: begin
        r = sa * sbv;
        x = 8'(r >>> 8);
        y = 8'(r);
      end
      2'd2: y = 8'(a & b);
      default: y = 8'(a ^ b);
    endcase
    return {i[17:16], o, c, x, y};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard for u0: record accepted pushes, compare every consumed result in order
  always @(negedge clk)
    if (rst_n) begin
      if (b0.res_valid && b0.res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_stale got result y=%0h with nothing pending", b0.res_y);
        end else
          chk("sb_result", {12'h0, b0.res_op, b0.res_ovf, b0.res_carry, b0.res_x, b0.res_y},
              {12'h0, ref_res(sb.pop_front())});
      end
      if (b0.in_valid && b0.in_ready) sb.push_back(b0.in_instr);
    end

  task automatic run_vec(input int k);
    b0.in_valid = 1'b1;
    b0.in_instr = tv[k].instr;
    tick;
    b0.in_valid = 1'b0;
    chk("lat_t", b0.res_valid, 1'b0);
    tick;
    chk("lat_t1", b0.res_valid, 1'b0);
    tick;
    chk("lat_t2", b0.res_valid, 1'b1);
    chk("vec_x", b0.res_x, tv[k].x);
    chk("vec_y", b0.res_y, tv[k].y);
    chk("vec_ovf", b0.res_ovf, tv[k].ovf);
    chk("vec_carry", b0.res_carry, tv[k].carry);
    chk("vec_op", b0.res_op, tv[k].instr[17:16]);
    b0.res_ready = 1'b1;
    tick;
    chk("vec_release", b0.res_valid, 1'b0);
    b0.res_ready = 1'b0;
  endtask

  task automatic drain;
    int n;
    b0.in_valid = 1'b0;
    b0.res_ready = 1'b1;
    for (n = 0; n < 400 && (sb.size() != 0 || busy0 || b0.res_valid); n++) tick;
    chk("drain_pending", sb.size(), 0);
    chk("drain_busy", busy0, 1'b0);
  endtask

  initial begin
    tv[0] = '{18'h07F01, 8'h00, 8'h80, 1'b1, 1'b0};
    tv[1] = '{18'h11010, 8'h01, 8'h00, 1'b0, 1'b0};
    tv[2] = '{18'h1FF02, 8'hFF, 8'hFE, 1'b0, 1'b0};
    tv[3] = '{18'h2F03C, 8'h00, 8'h30, 1'b0, 1'b0};
    tv[4] = '{18'h3FF0F, 8'h00, 8'hF0, 1'b0, 1'b0};
    tv[5] = '{18'h0FF01, 8'h00, 8'h00, 1'b0, 1'b1};
    tv[6] = '{18'h08080, 8'h00, 8'h00, 1'b1, 1'b1};
    tv[7] = '{18'h18080, 8'h40, 8'h00, 1'b0, 1'b0};
    tv[8] = '{18'h17F7F, 8'h3F, 8'h01, 1'b0, 1'b0};
    tv[9] = '{18'h00000, 8'h00, 8'h00, 1'b0, 1'b0};
    rst_n = 1'b0;
    rst1_n = 1'b0;
    b0.in_valid = 1'b0;
    b0.in_instr = '0;
    b0.res_ready = 1'b0;
    b1.in_valid = 1'b0;
    b1.in_instr = '0;
    b1.res_ready = 1'b0;
`ifdef ALU_SEQ_STAT_EN
    stat_clr0 = 1'b0;
    stat_clr1 = 1'b0;
`endif
    repeat (3) tick;
    chk("rst_res_valid", b0.res_valid, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_alu_instr", alu_instr0, 18'h0);
    chk("rst_res", {b0.res_op, b0.res_ovf, b0.res_carry, b0.res_x, b0.res_y}, 20'h0);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    tick;
    chk("rst_in_ready", b0.in_ready, 1'b1);

    foreach (tv[k]) run_vec(k);

    for (int k = 0; k < 6; k++) bp[k] = 18'($urandom);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ready", b0.in_ready, 1'b1);
      b0.in_valid = 1'b1;
      b0.in_instr = bp[k];
      tick;
    end
    b0.in_instr = bp[5];
    chk("bp_full", b0.in_ready, 1'b0);
    repeat (3) tick;
    chk("bp_hold_ready", b0.in_ready, 1'b0);
    chk("bp_hold_valid", b0.res_valid, 1'b1);
    chk("bp_hold_y", b0.res_y, ref_res(bp[0]) & 20'hFF);
    b0.res_ready = 1'b1;
    tick;
    chk("bp_release_ready", b0.in_ready, 1'b0);
    tick;
    chk("bp_pop_ready", b0.in_ready, 1'b1);
    tick;
    b0.in_valid = 1'b0;
    drain;

    for (int n = 0; n < 500; n++) begin
      b0.in_valid = 1'($urandom);
      b0.in_instr = 18'($urandom);
      b0.res_ready = $urandom_range(0, 3) != 0;
      tick;
    end
    drain;
    b0.res_ready = 1'b0;

    b1.in_valid = 1'b1;
    b1.in_instr = 18'h07F01;
    tick;
    b1.in_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick;
      chk("lat3_wait", b1.res_valid, 1'b0);
    end
    tick;
    chk("lat3_valid", b1.res_valid, 1'b1);
    chk("lat3_y", b1.res_y, 8'h80);
    chk("lat3_ovf", b1.res_ovf, 1'b1);
    b1.res_ready = 1'b1;
    tick;
    b1.res_ready = 1'b0;
    b1.in_valid = 1'b1;
    b1.in_instr = 18'h0FF01;
    tick;
    b1.in_instr = 18'h11010;
    tick;
    b1.in_valid = 1'b0;
    tick;
    chk("mid_exec_busy", busy1, 1'b1);
    #2 rst1_n = 1'b0;
    #1;
    chk("arst_res_valid", b1.res_valid, 1'b0);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_alu_instr", alu_instr1, 18'h0);
    tick;
    rst1_n = 1'b1;
    tick;
    chk("arst_in_ready", b1.in_ready, 1'b1);
    for (int j = 0; j < 8; j++) begin
      tick;
      chk("arst_no_stale", {busy1, b1.res_valid}, 2'b00);
    end

`ifdef ALU_SEQ_STAT_EN
    begin
      int acc = 0;
      stat_clr0 = 1'b1;
      tick;
      stat_clr0 = 1'b0;
      chk("stat_clr_ovf", ovf_cnt0, 8'h00);
      chk("stat_clr_carry", carry_cnt0, 8'h00);
      b0.res_ready = 1'b1;
      b0.in_instr = 18'h0FF01;
      for (int n = 0; n < 3000 && acc < 300; n++) begin
        b0.in_valid = 1'b1;
        if (b0.in_ready) acc++;
        tick;
      end
      b0.in_valid = 1'b0;
      chk("stat_pushed", acc, 300);
      drain;
      chk("stat_carry_sat", carry_cnt0, 8'hFF);
      chk("stat_ovf_none", ovf_cnt0, 8'h00);
      b0.res_ready = 1'b0;
      b0.in_valid = 1'b1;
      tick;
      b0.in_valid = 1'b0;
      tick;
      stat_clr0 = 1'b1;
      tick;
      stat_clr0 = 1'b0;
      chk("stat_clr_wins", carry_cnt0, 8'h00);
      chk("stat_clr_capture", b0.res_carry, 1'b1);
      b0.res_ready = 1'b1;
      tick;
      b0.res_ready = 1'b0;
      b0.in_valid = 1'b1;
      b0.in_instr = 18'h08080;
      tick;
      b0.in_valid = 1'b0;
      tick;
      tick;
      chk("stat_inc_ovf", ovf_cnt0, 8'h01);
      chk("stat_inc_carry", carry_cnt0, 8'h01);
      drain;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencing controller for the 8-bit ALU datapath (add / signed multiply / AND / XOR, opcode-selected, X:Y result pair, Overflow/Carry flags).
- Accepts 18-bit ALU instructions from an upstream requester through a valid/ready handshake and buffers them in a small FIFO.
- Issues one instruction at a time to the ALU and waits a fixed settle latency.
- Captures X, Y and flags into a result register and holds them on a valid/ready output handshake until the result is consumed.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of 2, minimum 2.
- ALU_LAT, 1, cycles alu_instr is held stable before results are sampled; minimum 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_instr  input  18  [17:16] opcode (00 add, 01 mul, 10 and, 11 xor), [15:8] operand A, [7:0] operand B.
- alu_instr  output  18  instruction driven to the ALU.
- alu_x  input  8  ALU high result byte.
- alu_y  input  8  ALU low result byte.
- alu_ovf  input  1  ALU Overflow.
- alu_carry  input  1  ALU Carry.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  downstream accepts the result.
- res_x  output  8  captured X.
- res_y  output  8  captured Y.
- res_ovf  output  1  captured Overflow, masked.
- res_carry  output  1  captured Carry, masked.
- res_op  output  2  opcode of the captured result.
- busy  output  1  high when not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO is emptied.
  - State is IDLE.
  - alu_instr=0, res_*=0, res_valid=0, busy=0.
  - in_ready is 1 once reset has deasserted.
- Push: the FIFO accepts at an edge where in_valid && in_ready.
  - in_ready depends only on the full flag.
  - A push while full is refused, even if a pop happens in the same cycle.
- FIFO: circular, with wrapping read and write pointers and an occupancy count of 0..DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
  - Ordering is strictly in order.
- State machine:
  - IDLE: if the FIFO is non-empty, pop the head into alu_instr, load the latency counter with ALU_LAT, and go to EXEC. Otherwise stay; alu_instr holds its last value.
  - EXEC: decrement the counter each cycle. At the edge where the counter reaches 0, perform the capture below and go to DONE.
    - Capture: res_x=alu_x, res_y=alu_y, res_op=alu_instr[17:16], res_valid=1.
    - Flag masking: res_ovf and res_carry take alu_ovf/alu_carry only when the opcode is 00, otherwise 0.
    - alu_instr remains constant throughout EXEC.
  - DONE: res_valid=1 and res_* are stable. On res_ready=1, clear res_valid at that edge and go to IDLE. With res_ready low, stay in DONE indefinitely; the FIFO still accepts pushes.
- Timing:
  - An instruction pushed at edge t into an empty FIFO with the controller in IDLE is popped at edge t+1.
  - It is captured at edge t+1+ALU_LAT, so res_valid is visible after that edge.
  - Back-to-back throughput is one result per ALU_LAT+2 cycles when res_ready is held high.
- Width rules:
  - X carries the multiply high byte.
  - For add, and and xor, the ALU supplies X=0 and the controller passes it through unchanged.
- Reset mid-operation: any state, pending FIFO contents and an unconsumed result are all discarded immediately.

Optional Feature:
- Macro: ALU_SEQ_STAT_EN.
- Defined: adds outputs ovf_cnt [7:0] and carry_cnt [7:0], plus input stat_clr.
  - Each counter increments by 1 at a capture edge whose masked res_ovf / res_carry is 1.
  - Counters saturate at 0xFF.
  - stat_clr=1 clears both at the next edge; a clear takes priority over an increment in the same cycle.
  - Both counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD: push 0x0_7F_01 -> res_y=0x80, res_x=0x00, res_ovf=1, res_carry=0, res_op=00; res_valid visible after edge t+2 (ALU_LAT=1).
- MUL: push 0x1_10_10 -> res_x=0x01, res_y=0x00, res_ovf=0, res_carry=0. MUL: push 0x1_FF_02 (-1*2) -> res_x=0xFF, res_y=0xFE.
- AND/XOR: push 0x2_F0_3C, then 0x3_FF_0F -> res_y=0x30 then 0xF0, res_x=0x00, flags masked to 0 even when the ALU's raw carry output is 1.
- Backpressure: hold res_ready=0 and push 6 instructions -> 1 instruction in DONE plus 4 in the FIFO, then in_ready=0 and the 6th is held off. Release res_ready -> results emerge in push order; in_ready rises one cycle after the first pop.
- Reset mid-EXEC with ALU_LAT=3: assert rst_n=0 asynchronously -> res_valid=0, busy=0 and in_ready=1 once rst_n deasserts; the FIFO is empty and no stale result appears afterwards.
- ALU_SEQ_STAT_EN: 300 ADDs of 0x0_FF_01 (carry=1) -> carry_cnt=0xFF saturated. Assert stat_clr on a capture cycle -> carry_cnt=0.
